// File: rtl/mux_tree_pkg.sv
// mux_tree_pkg: sizing helpers and the per-stage control bundle
// shared by the pipelined mux tree (mux_tree_pipe, mux_tree_seg).
package mux_tree_pkg;

  localparam int SEL_MAX = 32;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [SEL_MAX-1:0] sel_rem;
  } stage_ctl_t;

  function automatic int num_stages(
    input int sel_w,
    input int stage_lvls
  );
    return (sel_w + stage_lvls - 1) / stage_lvls;
  endfunction

  function automatic int pad_leaves(input int n_in);
    return 1 << $clog2(n_in);
  endfunction

endpackage

// File: rtl/mux_tree_seg.sv
// mux_tree_seg: combinational LVLS-level 2:1 reduction of NODES
// channels; level k picks odd/even pairs with sel[k], LSB first.
// Ports: d (NODES*DATA_W), sel (LVLS), q ((NODES>>LVLS)*DATA_W).
module mux_tree_seg
  import mux_tree_pkg::*;
#(
  parameter int NODES  = 8,
  parameter int LVLS   = 3,
  parameter int DATA_W = 1
) (
  input  logic [NODES*DATA_W-1:0]          d,
  input  logic [LVLS-1:0]                  sel,
  output logic [(NODES>>LVLS)*DATA_W-1:0]  q
);

  for (genvar k = 0; k <= LVLS; k++) begin : g_lv
    localparam int NK = NODES >> k;
    logic [NK*DATA_W-1:0] n;
    if (k == 0) begin : g_in
      assign n = d;
    end else begin : g_red
      for (genvar j = 0; j < NK; j++) begin : g_node
        assign n[j*DATA_W +: DATA_W] = sel[k-1]
          ? g_lv[k-1].n[(2*j+1)*DATA_W +: DATA_W]
          : g_lv[k-1].n[(2*j)*DATA_W +: DATA_W];
      end
    end
  end

  assign q = g_lv[LVLS].n;

endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N_IN:1 selector, a register slice every
// STAGE_LVLS tree levels, valid/ready on both ends.
// Ports: clk, rst (sync, active high); in_data/in_sel/in_valid ->
// in_ready; out_data/out_valid/out_err <- out_ready.
// Option: define MUX_TREE_PIPE_SEL_ERR_EN to flag in_sel >= N_IN
// on out_err; otherwise out_err is tied low.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int N_IN       = 512,
  parameter  int DATA_W     = 1,
  parameter  int STAGE_LVLS = 3,
  localparam int SEL_W      = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_err
);

  localparam int NP = pad_leaves(N_IN);
  localparam int P  = num_stages(SEL_W, STAGE_LVLS);

  logic [NP*DATA_W-1:0] leaves;
  logic [P:0]           en;
  logic [P-1:0]         vld;
  stage_ctl_t           ctl_in;

  if (NP > N_IN) begin : g_pad
    assign leaves = {{((NP-N_IN)*DATA_W){1'b0}}, in_data};
  end else begin : g_nopad
    assign leaves = in_data;
  end

  always_comb begin
    ctl_in = '0;
    ctl_in.valid = in_valid;
    ctl_in.sel_rem[SEL_W-1:0] = in_sel;
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    ctl_in.err = {1'b0, in_sel} >= (SEL_W+1)'(N_IN);
`endif
  end

  // A stage may load when empty or when its successor loads too.
  always_comb begin
    en = '0;
    en[P] = out_ready;
    for (int s = P - 1; s >= 0; s--) begin
      en[s] = !vld[s] || en[s+1];
    end
  end

  assign in_ready = en[0];

  for (genvar s = 0; s < P; s++) begin : g_st
    localparam int LO = s * STAGE_LVLS;
    localparam int LV = (SEL_W - LO < STAGE_LVLS)
                      ? SEL_W - LO : STAGE_LVLS;
    localparam int NI = NP >> LO;
    localparam int NO = NI >> LV;

    stage_ctl_t           c_in;
    logic [NI*DATA_W-1:0] d_in;
    logic [NO*DATA_W-1:0] d_nx;
    logic [NO*DATA_W-1:0] d_q;
    logic [SEL_MAX-1:0]   r_q;
    logic                 v_q;
    logic                 e_q;

    if (s == 0) begin : g_head
      assign c_in = ctl_in;
      assign d_in = leaves;
    end else begin : g_link
      assign c_in = '{
        valid:   g_st[s-1].v_q,
        err:     g_st[s-1].e_q,
        sel_rem: g_st[s-1].r_q
      };
      assign d_in = g_st[s-1].d_q;
    end

    mux_tree_seg #(
      .NODES  (NI),
      .LVLS   (LV),
      .DATA_W (DATA_W)
    ) u_seg (
      .d   (d_in),
      .sel (c_in.sel_rem[LV-1:0]),
      .q   (d_nx)
    );

    assign vld[s] = v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (en[s]) begin
        v_q <= c_in.valid;
      end
    end

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    always_ff @(posedge clk) begin
      if (rst) begin
        e_q <= 1'b0;
      end else if (en[s]) begin
        e_q <= c_in.err;
      end
    end
`else
    logic unused_err;
    assign unused_err = c_in.err;
    assign e_q = 1'b0;
`endif

    // Payload and consumed-sel shift register: no reset needed.
    always_ff @(posedge clk) begin
      if (en[s]) begin
        d_q <= d_nx;
        r_q <= c_in.sel_rem >> LV;
      end
    end
  end

  assign out_valid = vld[P-1];
  assign out_data  = g_st[P-1].d_q;
  assign out_err   = g_st[P-1].e_q;

  logic unused_rem;
  assign unused_rem = ^g_st[P-1].r_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: scoreboard bench for mux_tree_pipe over three
// configurations (512x1/L3, 5x8/L1, 2x1/L1).
module tb_mux_tree_pipe;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int NN  = (g == 0) ? 512 : (g == 1) ? 5 : 2;
    localparam int W   = (g == 1) ? 8 : 1;
    localparam int L   = (g == 0) ? 3 : 1;
    localparam int PL  = (g == 2) ? 1 : 3;
    localparam int SW  = $clog2(NN);
    localparam int DS0 = (g == 0) ? 300 : (g == 1) ? 4 : 1;
    localparam int DS1 = (g == 0) ? 301 : (g == 1) ? 6 : 0;
    localparam int NR  = (g == 0) ? 300 : 150;

    logic          rst, iv, ir, ov, ord, oe;
    logic [NN*W-1:0] din;
    logic [SW-1:0] isel;
    logic [W-1:0]  od;
    exp_t          q[$];
    int            last_stall = -1;
    bit            fin = 1'b0;
    bit            prev_rst = 1'b0;
    bit            held = 1'b0;
    logic [W-1:0]  hd;
    logic          he;
    exp_t          pe;

    mux_tree_pipe #(
      .N_IN       (NN),
      .DATA_W     (W),
      .STAGE_LVLS (L)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (din),
      .in_sel    (isel),
      .in_valid  (iv),
      .in_ready  (ir),
      .out_data  (od),
      .out_valid (ov),
      .out_ready (ord),
      .out_err   (oe)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d_%s", g, s);
    endfunction

    // Reference: channel s of the input, or zero beyond N_IN.
    function automatic exp_t model(input logic [NN*W-1:0] d,
                                   input int s, input int c);
      exp_t e;
      e.d = '0;
      e.e = 1'b0;
      e.c = c;
      if (s < NN) e.d[W-1:0] = d[s*W +: W];
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
      e.e = (s >= NN);
`endif
      return e;
    endfunction

    task automatic step(output bit acc);
      @(negedge clk);
      acc = iv && ir && !rst;
      if (acc) q.push_back(model(din, int'(isel), cyc));
      @(posedge clk);
      #1;
    endtask

    task automatic rand_din();
      for (int i = 0; i < NN*W; i++) din[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string s);
      bit a;
      int t;
      t = 0;
      iv = 1'b0;
      ord = 1'b1;
      while (q.size() != 0 && t < 50) begin
        step(a);
        t++;
      end
      chk(q.size() == 0, nm(s), q.size(), 0);
      repeat (2) step(a);
    endtask

    initial begin
      bit a;
      int acc;
      int t;
      int v;
      rst = 1'b1;
      iv = 1'b0;
      ord = 1'b1;
      din = '0;
      isel = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < NN; i++) begin
        v = (i + 1) * 17;
        if (W == 1) v = (i == DS0) ? 1 : 0;
        din[i*W +: W] = v[W-1:0];
      end
      iv = 1'b1;
      isel = SW'(DS0);
      step(a);
      isel = SW'(DS1);
      step(a);
      drain("directed");

      rand_din();
      iv = 1'b1;
      ord = 1'b1;
      for (int i = 0; i < NN; i++) begin
        isel = SW'(i);
        chk(ir == 1'b1, nm("sweep_ready"), ir, 1);
        step(a);
      end
      drain("sweep");

      for (int i = 0; i < NR; i++) begin
        rand_din();
        iv = ($urandom_range(0, 9) < 7);
        ord = ($urandom_range(0, 9) < 7);
        isel = SW'($urandom_range(0, (1 << SW) - 1));
        step(a);
      end
      drain("random");

      acc = 0;
      t = 0;
      while (acc < 10 && t < 100) begin
        rand_din();
        iv = 1'b1;
        isel = SW'($urandom_range(0, NN - 1));
        ord = !(t >= 4 && t < 9);
        if (t == 8) chk(ir == 1'b0, nm("bp_full"), ir, 0);
        step(a);
        if (a) acc++;
        t++;
      end
      chk(acc == 10, nm("bp_count"), acc, 10);
      drain("bp");

      ord = 1'b1;
      iv = 1'b1;
      for (int i = 0; i < 2; i++) begin
        rand_din();
        isel = SW'($urandom_range(0, NN - 1));
        step(a);
      end
      iv = 1'b0;
      rst = 1'b1;
      step(a);
      rst = 1'b0;
      rand_din();
      iv = 1'b1;
      isel = SW'($urandom_range(0, NN - 1));
      step(a);
      drain("post_reset");
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        prev_rst = 1'b1;
        held = 1'b0;
      end else begin
        if (prev_rst) begin
          chk(ov == 1'b0, nm("rst_valid"), ov, 0);
          chk(ir == 1'b1, nm("rst_ready"), ir, 1);
          chk(oe == 1'b0, nm("rst_err"), oe, 0);
          prev_rst = 1'b0;
        end
        if (held) begin
          chk(ov && od == hd && oe == he, nm("hold"), od, hd);
        end
        if (!ord) last_stall = cyc;
        if (ov && ord) begin
          chk(q.size() > 0, nm("extra_beat"), q.size(), 1);
          if (q.size() > 0) begin
            pe = q.pop_front();
            chk(od == pe.d[W-1:0], nm("data"), od, pe.d);
            chk(oe == pe.e, nm("err"), oe, pe.e);
            if (last_stall < pe.c)
              chk(cyc - pe.c == PL, nm("latency"), cyc - pe.c, PL);
            else
              chk(cyc - pe.c >= PL, nm("latency_min"), cyc - pe.c, PL);
          end
        end
        held = ov && !ord;
        hd = od;
        he = oe;
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)
           && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk(t < 20000, "timeout", t, 20000);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
